// File: rtl/dmx_dp.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_dp
//  Description : Registered 1-to-2 datapath demultiplexer. A single producer
//                hands 32-bit words over a valid/ready handshake; each word is
//                steered by SDx into one of two single-entry output slots. Each
//                slot has its own valid/ready handshake toward its consumer and
//                a saturating delivery counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1     system clock, rising edge
//    rst_n     in   1     synchronous active-low reset
//    in_valid  in   1     producer presents a word on DI
//    in_ready  out  1     word on DI is accepted this cycle
//    SDx       in   1     steering select in accept cycle (0 = ch1, 1 = ch2)
//    DI        in   W     input data
//    o1_valid  out  1     channel 1 slot holds a word
//    o1_ready  in   1     channel 1 consumer takes the word
//    DO1       out  W     channel 1 data
//    o2_valid  out  1     channel 2 slot holds a word
//    o2_ready  in   1     channel 2 consumer takes the word
//    DO2       out  W     channel 2 data
//    cnt1      out  CNTW  words delivered on channel 1 (saturating)
//    cnt2      out  CNTW  words delivered on channel 2 (saturating)
//    busy      out  1     either slot holds a word
// ============================================================================
module dmx_dp #(
    parameter int W    = 32,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            SDx,
    input  logic [W-1:0]    DI,
    output logic            o1_valid,
    input  logic            o1_ready,
    output logic [W-1:0]    DO1,
    output logic            o2_valid,
    input  logic            o2_ready,
    output logic [W-1:0]    DO2,
    output logic [CNTW-1:0] cnt1,
    output logic [CNTW-1:0] cnt2,
    output logic            busy
);

    localparam int              NCH       = 2;
    localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};

    // Per-channel views, index 0 = channel 1, index 1 = channel 2.
    logic [NCH-1:0] w_ready;
    logic [NCH-1:0] w_valid;
    logic [NCH-1:0] w_drain;
    logic [NCH-1:0] w_slot_free;
    logic [NCH-1:0] w_load;
    logic [W-1:0]   w_data [NCH];
    logic [CNTW-1:0] w_cnt [NCH];
    logic           w_accept;

    assign w_ready = {o2_ready, o1_ready};

    // A ready with an empty slot is ignored, so drains only happen on held words.
    assign w_drain = w_valid & w_ready;

    // A slot can take a word if it is empty or is being emptied this cycle.
    // The drain term makes in_ready depend combinationally on ok_ready, which
    // is what allows one word per cycle through a continuously draining slot.
    assign w_slot_free = ~w_valid | w_drain;

    assign in_ready = rst_n & (SDx ? w_slot_free[1] : w_slot_free[0]);
    assign w_accept = in_valid & in_ready;

    // Only the selected channel loads; the other one is left untouched, so a
    // stalled channel never holds up words routed to its neighbour.
    assign w_load = {w_accept & SDx, w_accept & ~SDx};

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic            valid_q;
            logic            valid_d;
            logic [W-1:0]    data_q;
            logic [W-1:0]    data_d;
            logic [CNTW-1:0] cnt_q;
            logic [CNTW-1:0] cnt_d;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                cnt_d   = cnt_q;

                // Load wins over drain: a simultaneous drain and load keeps
                // valid high with the new word (back-to-back transfer).
                if (w_load[k]) begin
                    valid_d = 1'b1;
                    data_d  = DI;
                end else if (w_drain[k]) begin
                    // Data register keeps its last value after the drain.
                    valid_d = 1'b0;
                end

                if (w_drain[k] && (cnt_q != C_CNT_MAX)) begin
                    cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    cnt_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign w_valid[k] = valid_q;
            assign w_data[k]  = data_q;
            assign w_cnt[k]   = cnt_q;
        end
    endgenerate

    assign o1_valid = w_valid[0];
    assign o2_valid = w_valid[1];
    assign DO1      = w_data[0];
    assign DO2      = w_data[1];
    assign cnt1     = w_cnt[0];
    assign cnt2     = w_cnt[1];
    assign busy     = |w_valid;

endmodule
`default_nettype wire
